flag_sequencer: RTL and testbench
=================================

# flag_sequencer

Multi-cycle control block that sequences one ALU instruction through execute, flag write-back and branch-condition evaluation. It generates the `c14` write strobe for `flag_reg` and reads back the 4-bit flag vector `y` to resolve conditional branches. It sits between the instruction decode/control unit (valid/ready handshake) and the ALU/flag datapath.

## Interface
Parameters:
- `ALU_LAT`, default 1: ALU result latency in cycles. Legal range is 1–4.

Ports:
- `clk`, in, 1: system clock. All state updates on the posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `instr_valid`, in, 1: decode presents an instruction.
- `instr_ready`, out, 1: the sequencer can accept an instruction. A transfer occurs when `instr_valid & instr_ready` at a posedge.
- `flag_we`, in, 1: the instruction updates flags. Sampled on transfer.
- `is_branch`, in, 1: the instruction is a conditional branch. Sampled on transfer.
- `cond`, in, 4: branch condition code. Sampled on transfer.
- `flags`, in, 4: flag register output. Bit 0 = Z, bit 1 = N, bit 2 = V, bit 3 = C.
- `alu_go`, out, 1: one-cycle ALU start pulse.
- `c14`, out, 1: flag register write enable, asserted for one cycle.
- `done`, out, 1: one-cycle completion pulse.
- `branch_taken`, out, 1: branch resolution result.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, WRITE, EVAL, DONE. Outputs are Moore-decoded from state and registers.
- **IDLE**
  - `instr_ready` = 1.
  - On transfer: latch `flag_we`, `is_branch`, `cond`; load the counter with `ALU_LAT`−1; clear `branch_taken`; go to EXEC.
- **EXEC**
  - `alu_go` = 1 only in the first EXEC cycle.
  - The counter decrements each cycle.
  - When the counter is 0, the next state is:
    - WRITE if `flag_we`;
    - else EVAL if `is_branch`;
    - else DONE.
- **WRITE**
  - `c14` = 1 for exactly one cycle.
  - `flag_reg` captures on the negedge inside this cycle, so `flags` is stable by the next posedge.
  - Next state is EVAL if `is_branch`, else DONE.
- **EVAL**
  - Evaluate the latched `cond` against `flags` and register the result into `branch_taken` at the end of the cycle.
  - Go to DONE.
- **DONE**
  - `done` = 1 for one cycle, then return to IDLE.
  - `branch_taken` holds its value until the next transfer. It is 0 for non-branch instructions.
- Condition codes (value: meaning, taken when):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C & !Z
  - 9 LS: !C | Z
  - 10 GE: N == V
  - 11 LT: N != V
  - 12 GT: !Z & (N == V)
  - 13 LE: Z | (N != V)
  - 14 AL: always taken
  - 15 NV: never taken
- `instr_valid` outside IDLE is ignored. Decode must hold it until `instr_ready`.

## Timing
- **Reset.** While `rst` = 1:
  - next state is IDLE; counter and latched fields are cleared;
  - `instr_ready`, `alu_go`, `c14`, `done`, `branch_taken`, `busy` are all forced to 0;
  - `c14` is gated combinationally with `!rst`, so reset asserted during WRITE suppresses the flag write in that cycle.
- **After reset.** In the first cycle after `rst` deasserts, the block is in IDLE with `instr_ready` = 1.
- **Reset mid-operation.** Abandons the instruction. No `done` is produced and no later `c14` is issued.
- **Latency.** Transfer at posedge k. EXEC occupies cycles k+1 .. k+`ALU_LAT`.
  - With flag write and branch: WRITE at k+`ALU_LAT`+1, EVAL at +2, DONE at +3.
  - Flag write only: DONE at k+`ALU_LAT`+2.
  - Branch only: EVAL at k+`ALU_LAT`+1, DONE at +2.
  - Neither: DONE at k+`ALU_LAT`+1.
- **Throughput.** IDLE is re-entered after DONE, so back-to-back instructions have one IDLE cycle between them. No overlap.
- **Sampling of `flags`.** Sampled only in EVAL. A branch with `flag_we` = 1 sees the flags written in the preceding WRITE. A branch with `flag_we` = 0 sees the prior flags.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `instr_valid` = 1 → no transfer, all outputs 0. First post-reset cycle: `instr_ready` = 1, `busy` = 0.
- **Flag write only.** `ALU_LAT` = 1; send `flag_we` = 1, `is_branch` = 0 → `alu_go` at k+1, `c14` single pulse at k+2, `done` at k+3, `branch_taken` = 0.
- **Write then branch.** `flag_we` = 1, `is_branch` = 1, `cond` = 0 (EQ); the ALU drives zero = 1 so `flags` becomes 4'b0001 after WRITE → `done` at k+4 with `branch_taken` = 1. Repeat with `cond` = 1 (NE) → `branch_taken` = 0.
- **Condition sweep.** For all 16 `cond` values × 16 `flags` values, with `flag_we` = 0 and `is_branch` = 1 → `branch_taken` matches the condition table in every case (256 checks).
- **Reset in WRITE, and long latency.** `ALU_LAT` = 3; assert `rst` in the WRITE cycle → `c14` stays 0, `flags` unchanged, no `done`, IDLE on the next cycle. Then send an instruction with `flag_we` = 0, `is_branch` = 0 → `done` exactly at k+4.
- **Back-to-back and ignored valid.** Hold `instr_valid` = 1 continuously → transfers occur only in IDLE cycles, spaced per the latency rules. `instr_valid` asserted while `busy` = 1 does not alter the latched `cond`.

Source files
------------

// File: rtl/flag_sequencer.sv
// flag_sequencer: sequences one ALU instruction through execute, flag write-back and branch-condition evaluation
module flag_sequencer #(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       flag_we,
  input  logic       is_branch,
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       alu_go,
  output logic       c14,
  output logic       done,
  output logic       branch_taken,
  output logic       busy
);
  localparam logic [2:0] IDLE = 3'd0, EXEC = 3'd1, WRITE = 3'd2, EVAL = 3'd3, DONE = 3'd4;
  localparam logic [1:0] CNT_INIT = 2'(ALU_LAT - 1);
  logic [2:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [3:0] cond_q, cond_d;
  logic fwe_q, fwe_d, br_q, br_d, bt_q, bt_d;
  logic [7:0] base;
  logic take;
  always_comb begin
    base = {1'b1, !flags[0] && (flags[1] == flags[2]), flags[1] == flags[2], flags[3] && !flags[0],
            flags[2], flags[1], flags[3], flags[0]};
    take = base[cond_q[3:1]] ^ cond_q[0];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cond_d = cond_q;
    fwe_d = fwe_q;
    br_d = br_q;
    bt_d = bt_q;
    case (state_q)
      IDLE: if (instr_valid) begin
        state_d = EXEC;
        cnt_d = CNT_INIT;
        cond_d = cond;
        fwe_d = flag_we;
        br_d = is_branch;
        bt_d = 1'b0;
      end
      EXEC: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) state_d = fwe_q ? WRITE : br_q ? EVAL : DONE;
      end
      WRITE: state_d = br_q ? EVAL : DONE;
      EVAL: begin
        bt_d = take;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= 2'd0;
      cond_q <= 4'd0;
      fwe_q <= 1'b0;
      br_q <= 1'b0;
      bt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cond_q <= cond_d;
      fwe_q <= fwe_d;
      br_q <= br_d;
      bt_q <= bt_d;
    end
  end
  assign instr_ready = !rst && state_q == IDLE;
  assign busy = !rst && state_q != IDLE;
  assign alu_go = !rst && state_q == EXEC && cnt_q == CNT_INIT;
  assign c14 = !rst && state_q == WRITE;
  assign done = !rst && state_q == DONE;
  assign branch_taken = !rst && bt_q;
endmodule

// File: tb/tb_flag_sequencer.sv
// tb_flag_sequencer: scoreboard bench driving two flag_sequencer instances (ALU_LAT 1 and 3)
module tb_flag_sequencer;
  typedef struct {int k; int due; logic fwe; logic bt;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int n_tests = 0;
  int n_fail = 0;
  int s = 0;
  logic [1:0] iv = 2'b00, fwe = 2'b00, br = 2'b00;
  logic [3:0] cnd [2] = '{4'h0, 4'h0};
  logic [3:0] wv [2] = '{4'h0, 4'h0};
  logic [3:0] flg [2] = '{4'h0, 4'h0};
  logic [3:0] alu_res [2] = '{4'h0, 4'h0};
  logic ld = 1'b0;
  logic [3:0] ld_val = 4'h0;
  logic [1:0] last_bt = 2'b00;
  wire [1:0] rdy, go, c14, dn, bt, busy;
  exp_t q[$];
  flag_sequencer #(.ALU_LAT(1)) u_lat1 (.clk(clk), .rst(rst), .instr_valid(iv[0]), .instr_ready(rdy[0]),
    .flag_we(fwe[0]), .is_branch(br[0]), .cond(cnd[0]), .flags(flg[0]), .alu_go(go[0]), .c14(c14[0]),
    .done(dn[0]), .branch_taken(bt[0]), .busy(busy[0]));
  flag_sequencer #(.ALU_LAT(3)) u_lat3 (.clk(clk), .rst(rst), .instr_valid(iv[1]), .instr_ready(rdy[1]),
    .flag_we(fwe[1]), .is_branch(br[1]), .cond(cnd[1]), .flags(flg[1]), .alu_go(go[1]), .c14(c14[1]),
    .done(dn[1]), .branch_taken(bt[1]), .busy(busy[1]));
  function automatic int lat(input int i);
    return i != 0 ? 3 : 1;
  endfunction
  function automatic logic cond_ref(input logic [3:0] c, input logic [3:0] f);
    logic z, n, v, cy;
    z = f[0];
    n = f[1];
    v = f[2];
    cy = f[3];
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return cy;
      4'd3: return !cy;
      4'd4: return n;
      4'd5: return !n;
      4'd6: return v;
      4'd7: return !v;
      4'd8: return cy && !z;
      4'd9: return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, dut %0d)", nm, got, exp, cyc, s);
    end
  endtask
  // flag register: captures the ALU result on the negedge while c14 is high
  always @(negedge clk)
    for (int i = 0; i < 2; i++)
      if (c14[i]) flg[i] <= alu_res[i];
      else if (ld && s == i) flg[i] <= ld_val;
  // monitor: compares every cycle against the scoreboard head, then records new transfers
  always @(negedge clk) begin
    exp_t e;
    logic act;
    if (rst) begin
      for (int i = 0; i < 2; i++) chk("reset_outputs", {2'b00, rdy[i], go[i], c14[i], dn[i], bt[i], busy[i]}, 8'h00);
      q.delete();
      last_bt = 2'b00;
    end else begin
      act = q.size() > 0;
      e = act ? q[0] : '{0, 0, 1'b0, 1'b0};
      chk("busy", busy[s], act);
      chk("instr_ready", rdy[s], !act);
      chk("alu_go", go[s], act && cyc == e.k);
      chk("c14", c14[s], act && e.fwe && cyc == e.k + lat(s));
      chk("done", dn[s], act && cyc == e.due);
      chk("branch_taken", bt[s], act ? (cyc == e.due && e.bt) : last_bt[s]);
      if (act && cyc >= e.due) begin
        last_bt[s] = e.bt;
        void'(q.pop_front());
      end
      if (iv[s] && rdy[s]) begin
        q.push_back('{cyc + 1, cyc + 1 + lat(s) + int'(fwe[s]) + int'(br[s]), fwe[s],
                     br[s] && cond_ref(cnd[s], fwe[s] ? wv[s] : flg[s])});
        alu_res[s] <= wv[s];
      end
    end
  end
  task automatic issue(input logic f, input logic b, input logic [3:0] c, input logic [3:0] w, output int k);
    @(posedge clk);
    #1;
    iv[s] = 1'b1;
    fwe[s] = f;
    br[s] = b;
    cnd[s] = c;
    wv[s] = w;
    k = -1;
    for (int t = 0; t < 40 && k < 0; t++) begin
      @(negedge clk);
      if (rdy[s]) begin
        @(posedge clk);
        #1;
        k = cyc;
      end
    end
    iv[s] = 1'b0;
    if (k < 0) chk("transfer_timeout", 8'd1, 8'd0);
  endtask
  task automatic wait_idle();
    int t;
    for (t = 0; t < 60; t++) begin
      @(negedge clk);
      if (q.size() == 0 && rdy[s]) break;
    end
    if (t == 60) chk("idle_timeout", 8'd1, 8'd0);
  endtask
  task automatic preload(input logic [3:0] v);
    @(posedge clk);
    #1;
    ld_val = v;
    ld = 1'b1;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    iv[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", rdy[0], 1'b1);
    chk("post_reset_busy", busy[0], 1'b0);
    issue(1'b1, 1'b0, 4'd0, 4'h5, k);
    wait_idle();
    chk("flag_write_value", flg[0], 4'h5);
    chk("flag_write_bt", last_bt[0], 1'b0);
    preload(4'h0);
    issue(1'b1, 1'b1, 4'd0, 4'b0001, k);
    wait_idle();
    chk("write_eq_taken", last_bt[0], 1'b1);
    issue(1'b1, 1'b1, 4'd1, 4'b0001, k);
    wait_idle();
    chk("write_ne_taken", last_bt[0], 1'b0);
    for (int c = 0; c < 16; c++)
      for (int f = 0; f < 16; f++) begin
        preload(4'(f));
        issue(1'b0, 1'b1, 4'(c), 4'($urandom), k);
        wait_idle();
      end
    s = 1;
    preload(4'h0);
    issue(1'b1, 1'b0, 4'd0, 4'hF, k);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_write_ready", rdy[1], 1'b1);
    chk("reset_write_flags", flg[1], 4'h0);
    issue(1'b0, 1'b0, 4'd14, 4'h3, k);
    wait_idle();
    for (int i = 0; i < 60; i++) begin
      s = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) preload(4'($urandom));
      issue(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), k);
      wait_idle();
    end
    for (int j = 0; j < 2; j++) begin
      s = j;
      @(posedge clk);
      #1;
      iv[s] = 1'b1;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk);
        #1;
        fwe[s] = 1'($urandom);
        br[s] = 1'($urandom);
        cnd[s] = 4'($urandom);
        wv[s] = 4'($urandom);
      end
      iv[s] = 1'b0;
      wait_idle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
